// File: rtl/bit_destuffer_pkg.sv
// bit_destuffer_pkg: shared state type, defaults and width helper for the bit destuffer
package bit_destuff_pkg;
  typedef enum logic [1:0] {S_RUN, S_STUFF, S_ERR} destuff_state_t;
  localparam int DEF_RUN_LEN = 6;
  function automatic int cnt_w(input int run_len);
    return $clog2(run_len + 1);
  endfunction
endpackage

// File: rtl/bit_destuffer_flex_counter.sv
// flex_counter: up-counter with sync clear that wraps to 1 after reaching rollover_val
module flex_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         count_enable,
  input  logic [W-1:0] rollover_val,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (!n_rst || clear) count <= '0;
    else if (count_enable) count <= (count == rollover_val) ? W'(1) : count + W'(1);
endmodule

// File: rtl/bit_destuffer.sv
// bit_destuffer: drops the stuffed bit after RUN_LEN run bits and flags stuffing violations
module bit_destuffer
  import bit_destuff_pkg::*;
#(
  parameter int   RUN_LEN   = DEF_RUN_LEN,
  parameter logic RUN_VAL   = 1'b1,
  parameter int   CNT_W     = cnt_w(RUN_LEN),
  parameter int   ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 shift_enable,
  input  logic                 d_orig,
  output logic                 shift_stop,
  output logic                 stuff_err,
  output logic                 err_hold,
  output logic [CNT_W-1:0]     run_count,
  output logic [ERR_CNT_W-1:0] err_count
);
  destuff_state_t state;
  logic run_bit, in_run;
  assign run_bit = d_orig == RUN_VAL;
  assign in_run = state == S_RUN;
  assign shift_stop = shift_enable & enable & ~in_run;
  // any strobe outside S_RUN, or a non-run bit inside it, restarts the run
  flex_counter #(.W(CNT_W)) u_run_cnt (
    .clk,
    .n_rst,
    .clear(clear | ~enable | (shift_enable & (~in_run | ~run_bit))),
    .count_enable(shift_enable & run_bit & in_run),
    .rollover_val(CNT_W'(RUN_LEN)),
    .count(run_count)
  );
  always_ff @(posedge clk)
    if (!n_rst || clear || !enable) begin
      state <= S_RUN;
      stuff_err <= 1'b0;
      err_hold <= 1'b0;
      if (!n_rst) err_count <= '0;
    end else begin
      stuff_err <= 1'b0;
      if (shift_enable && in_run && run_bit && run_count == CNT_W'(RUN_LEN - 1)) state <= S_STUFF;
      else if (shift_enable && state == S_STUFF) begin
        state <= run_bit ? S_ERR : S_RUN;
        stuff_err <= run_bit;
        err_hold <= run_bit;
        if (run_bit) err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, ~&err_count};
      end
    end
endmodule

// File: tb/tb_bit_destuffer.sv
// tb_bit_destuffer: scoreboard bench for a default (6,1) and a (3,0) destuffer instance
module tb_bit_destuffer;
  typedef logic [13:0] vec_t;
  logic clk = 0, n_rst = 1, enable = 1, clear = 0, shift_enable = 0, d_orig = 0;
  logic st1, se1, eh1, st2, se2, eh2;
  logic [2:0] rc1;
  logic [1:0] rc2;
  logic [7:0] ec1, ec2;
  int checks = 0, errors = 0;
  vec_t q[$];
  vec_t e;
  logic s1, s2;

  bit_destuffer dut1 (
    .clk(clk), .n_rst(n_rst), .enable(enable), .clear(clear), .shift_enable(shift_enable),
    .d_orig(d_orig), .shift_stop(st1), .stuff_err(se1), .err_hold(eh1), .run_count(rc1), .err_count(ec1)
  );
  bit_destuffer #(.RUN_LEN(3), .RUN_VAL(1'b0)) dut2 (
    .clk(clk), .n_rst(n_rst), .enable(enable), .clear(clear), .shift_enable(shift_enable),
    .d_orig(d_orig), .shift_stop(st2), .stuff_err(se2), .err_hold(eh2), .run_count(rc2), .err_count(ec2)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input int c, input logic er, input logic h, input int n);
    return {s, 3'(c), er, h, 8'(n)};
  endfunction
  function automatic vec_t obs1(input logic s);
    return {s, rc1, se1, eh1, ec1};
  endfunction
  function automatic vec_t obs2(input logic s);
    return {s, 1'b0, rc2, se2, eh2, ec2};
  endfunction

  task automatic step(input logic se, input logic d, input logic clr, output logic o1, output logic o2);
    @(negedge clk);
    shift_enable = se;
    d_orig = d;
    clear = clr;
    #1;
    o1 = st1;
    o2 = st2;
    @(posedge clk);
    #1;
    shift_enable = 0;
    clear = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_rst = 0; enable = 1; shift_enable = 1; d_orig = 1; clear = 0;
    @(posedge clk);
    #1;
    q.push_back(mk(0, 0, 0, 0, 0));
    e = q.pop_front();
    checks++;
    if (obs1(st1) !== e) begin
      errors++;
      $display("FAIL reset dut1 got %h want %h", obs1(st1), e);
    end
    q.push_back(mk(0, 0, 0, 0, 0));
    e = q.pop_front();
    checks++;
    if (obs2(st2) !== e) begin
      errors++;
      $display("FAIL reset dut2 got %h want %h", obs2(st2), e);
    end
    n_rst = 1; shift_enable = 0; d_orig = 0;
  endtask

  task automatic test_stuff;
    int b[8] = '{1, 1, 1, 1, 1, 1, 0, 1};
    int c[8] = '{1, 2, 3, 4, 5, 6, 0, 1};
    for (int i = 0; i < 8; i++) begin
      q.push_back(mk(i == 6, c[i], 0, 0, 0));
      step(1, b[i][0], 0, s1, s2);
      e = q.pop_front();
      checks++;
      if (obs1(s1) !== e) begin
        errors++;
        $display("FAIL stuff[%0d] got %h want %h", i, obs1(s1), e);
      end
      repeat (7) @(posedge clk);
    end
  endtask

  task automatic test_run_break;
    int b[11] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0};
    int c[11] = '{1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 0};
    step(0, 0, 1, s1, s2);
    for (int i = 0; i < 11; i++) begin
      q.push_back(mk(i == 10, c[i], 0, 0, 0));
      step(1, b[i][0], 0, s1, s2);
      e = q.pop_front();
      checks++;
      if (obs1(s1) !== e) begin
        errors++;
        $display("FAIL run_break[%0d] got %h want %h", i, obs1(s1), e);
      end
    end
  endtask

  task automatic test_violation;
    step(0, 0, 1, s1, s2);
    for (int i = 0; i < 10; i++) begin
      q.push_back(i < 6 ? mk(0, i + 1, 0, 0, 0) : mk(1, 0, i == 6, 1, 1));
      step(1, 1, 0, s1, s2);
      e = q.pop_front();
      checks++;
      if (obs1(s1) !== e) begin
        errors++;
        $display("FAIL violation[%0d] got %h want %h", i, obs1(s1), e);
      end
    end
    q.push_back(mk(0, 0, 0, 0, 1));
    step(0, 0, 1, s1, s2);
    e = q.pop_front();
    checks++;
    if (obs1(s1) !== e) begin
      errors++;
      $display("FAIL violation_clear got %h want %h", obs1(s1), e);
    end
  endtask

  task automatic test_bypass;
    enable = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) enable = 1;
      q.push_back(mk(0, i < 10 ? 0 : i - 9, 0, 0, 1));
      step(1, 1, 0, s1, s2);
      e = q.pop_front();
      checks++;
      if (obs1(s1) !== e) begin
        errors++;
        $display("FAIL bypass[%0d] got %h want %h", i, obs1(s1), e);
      end
    end
  endtask

  task automatic test_mid_reset;
    step(0, 0, 1, s1, s2);
    repeat (6) step(1, 1, 0, s1, s2);
    @(negedge clk);
    n_rst = 0; shift_enable = 1; d_orig = 1;
    @(posedge clk);
    #1;
    n_rst = 1; shift_enable = 0;
    q.push_back(mk(0, 0, 0, 0, 0));
    e = q.pop_front();
    checks++;
    if (obs1(1'b0) !== e) begin
      errors++;
      $display("FAIL mid_reset got %h want %h", obs1(1'b0), e);
    end
    q.push_back(mk(0, 0, 0, 0, 0));
    step(1, 0, 0, s1, s2);
    e = q.pop_front();
    checks++;
    if (obs1(s1) !== e) begin
      errors++;
      $display("FAIL mid_reset_after got %h want %h", obs1(s1), e);
    end
  endtask

  task automatic test_param;
    int b[4] = '{0, 0, 0, 1};
    int c[4] = '{1, 2, 3, 0};
    step(0, 0, 1, s1, s2);
    for (int i = 0; i < 4; i++) begin
      q.push_back(mk(i == 3, c[i], 0, 0, 0));
      step(1, b[i][0], 0, s1, s2);
      e = q.pop_front();
      checks++;
      if (obs2(s2) !== e) begin
        errors++;
        $display("FAIL param[%0d] got %h want %h", i, obs2(s2), e);
      end
    end
  endtask

  task automatic test_clear_collision;
    repeat (3) step(1, 0, 0, s1, s2);
    q.push_back(mk(1, 0, 0, 0, 0));
    step(1, 0, 1, s1, s2);
    e = q.pop_front();
    checks++;
    if (obs2(s2) !== e) begin
      errors++;
      $display("FAIL clear_collision got %h want %h", obs2(s2), e);
    end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 258; i++) begin
      repeat (3) step(1, 0, 0, s1, s2);
      q.push_back(mk(1, 0, 1, 1, i < 255 ? i + 1 : 255));
      step(1, 0, 0, s1, s2);
      e = q.pop_front();
      checks++;
      if (obs2(s2) !== e) begin
        errors++;
        $display("FAIL saturate[%0d] got %h want %h", i, obs2(s2), e);
      end
      step(0, 0, 1, s1, s2);
    end
  endtask

  initial begin
    test_reset;
    test_stuff;
    test_run_break;
    test_violation;
    test_bypass;
    test_mid_reset;
    test_param;
    test_clear_collision;
    test_saturate;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bit_destuffer.md
Name: bit_destuffer

Overview:
- Parametrised successor to the USB receive-path bit unstuffer.
- Sits between the NRZI decoder/edge detector and the receive shift register.
- Counts consecutive run bits. After RUN_LEN of them, suppresses the next shift (the stuffed bit) with a same-cycle shift_stop.
- New over the previous generation: configurable run length and polarity, stuff-error detection with an error-hold state, a bypass mode, and a saturating error counter.

Parameters:
RUN_LEN, 6, consecutive run bits that trigger a stuffed-bit skip (legal range 2..15)
RUN_VAL, 1'b1, bit value that forms a run; the stuffed bit must be ~RUN_VAL
CNT_W, $clog2(RUN_LEN+1), run counter width (derived, do not override)
ERR_CNT_W, 8, width of saturating stuff-error counter

Ports:
clk  input  1  system clock
n_rst  input  1  synchronous active-low reset
enable  input  1  1 = unstuffing active; 0 = bypass (shift_stop never asserted)
clear  input  1  packet-boundary clear (EOP/SOP); synchronous, 1 cycle
shift_enable  input  1  bit strobe; d_orig is valid this cycle
d_orig  input  1  decoded data bit
shift_stop  output  1  combinational; suppress shift of the current bit
stuff_err  output  1  registered 1-cycle pulse on a stuff violation
err_hold  output  1  registered level; high while in S_ERR
run_count  output  CNT_W  current run length (registered)
err_count  output  ERR_CNT_W  saturating count of stuff violations

Behaviour:
- Reset (n_rst=0 at rising clk, synchronous):
  - state=S_RUN, run_count=0, stuff_err=0, err_hold=0, err_count=0.
  - shift_stop=0 because state is S_RUN.
- Priority per cycle: n_rst > clear > enable=0 > shift_enable > hold.
- clear=1:
  - next state S_RUN, run_count=0, err_hold=0, stuff_err=0.
  - err_count is unchanged; only n_rst clears it.
- enable=0:
  - next state S_RUN, run_count=0, shift_stop=0.
  - err_count is held.
- States:
  - S_RUN, accumulating.
    - On shift_enable with d_orig==RUN_VAL: run_count+1.
    - If that increment makes run_count==RUN_LEN: go to S_STUFF and keep run_count=RUN_LEN.
    - On shift_enable with d_orig!=RUN_VAL: run_count=0.
  - S_STUFF, expecting the stuffed bit.
    - shift_stop = shift_enable (same cycle, combinational).
    - Next shift_enable with d_orig==~RUN_VAL: go to S_RUN, run_count=0.
    - Next shift_enable with d_orig==RUN_VAL: violation. Go to S_ERR, stuff_err=1 next cycle, err_count+1 (saturating at all-ones), run_count=0.
  - S_ERR, packet corrupt.
    - shift_stop = shift_enable for every strobe.
    - err_hold=1. Stays until clear or n_rst; no further stuff_err pulses.
- shift_stop:
  - Equals shift_enable & enable & (state==S_STUFF | state==S_ERR).
  - Zero latency; downstream gates its shift with it.
- Without shift_enable, state and counters hold, and shift_stop=0.
- Back-to-back shift_enable every cycle is supported (strobe spacing 1..N cycles).
- n_rst mid-run or mid-S_STUFF: all state is lost, with no pending stuff_err.
- clear in the same cycle as a violating bit: clear wins; no stuff_err and no err_count increment.
- err_count at max: stays at max; stuff_err still pulses.

Decomposition:
- Package bit_destuff_pkg holds:
  - typedef enum logic [1:0] {S_RUN, S_STUFF, S_ERR} destuff_state_t
  - localparam DEF_RUN_LEN=6
  - function for CNT_W
- Sub-module: reuse the team's flex_counter for run_count.
  - Wire its clear from (clear | ~enable | non-run bit | state exit).
  - Count-enable = shift_enable & d_orig==RUN_VAL & state==S_RUN.
  - Rollover value = RUN_LEN.
- FSM, error counter and shift_stop logic live in bit_destuffer.

Test Plan:
- Reset with all inputs high (enable=1, shift_enable=1, d_orig=1), n_rst=0 one cycle -> run_count=0, shift_stop=0, err_count=0, stuff_err=0.
- RUN_LEN=6, strobes every 8 clocks, bits 1,1,1,1,1,1,0,1 -> run_count goes 1..6, then shift_stop=1 only on the 7th strobe; after it run_count=0, then 1; no stuff_err.
- Run broken by a 0 bit: bits 1,1,1,0,1,1,1,1,1,1,0 -> run_count resets to 0 at the 4th strobe; shift_stop asserts only on the 11th strobe.
- Violation, continuous strobes, d_orig=1 for 7 bits -> shift_stop=1 on strobe 7, then stuff_err 1-cycle pulse, err_hold=1, err_count=1. Strobes 8–10 all have shift_stop=1. Pulse clear -> err_hold=0, err_count stays 1.
- Bypass: enable=0, 10 one-bits -> shift_stop never asserts, run_count=0. Raising enable mid-stream starts a fresh count from 0.
- Parameter sweep RUN_LEN=3, RUN_VAL=0: bits 0,0,0,1 -> shift_stop on the 4th strobe. Also force 2^ERR_CNT_W+2 violations (clear between each) -> err_count saturates at 255 for ERR_CNT_W=8.
